// File: rtl/arm_alu_mc.sv
// arm_alu_mc: multicycle ALU with iterative shift-add multiplier and load-wait path
module arm_alu_mc #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       inst,
  input  logic [WIDTH-1:0] rd_data,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] data_b,
  input  logic             data_valid,
  output logic [WIDTH-1:0] d_out,
  output logic             wen,
  output logic             done,
  output logic             busy,
  output logic             flag_z,
  output logic             flag_c
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, EXEC, MUL, LDW, WB} state_t;
  state_t state, state_n;
  logic [4:0] inst_q;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_n, res;
  logic [WIDTH:0] sum;
  logic [CW-1:0] cnt;
  logic arm, cin, cy, last;
  logic [2:0] op;
  assign arm = inst_q[4];
  assign op = inst_q[3:1];
  assign cin = inst_q[0];
  assign acc_n = acc + (b_q[0] ? a_q : '0);
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state != IDLE;
  assign done = state == WB;
  assign wen = done && arm;
  always_comb begin
    sum = '0;
    res = a_q;
    cy = 1'b0;
    case (op)
      3'b000: begin
        sum = {1'b0, a_q} + {1'b0, b_q};
        res = sum[WIDTH-1:0];
        cy = sum[WIDTH];
      end
      3'b001: begin
        sum = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
        res = sum[WIDTH-1:0];
        cy = sum[WIDTH];
      end
      3'b010: res = b_q + WIDTH'(cin);
      3'b011: begin
        res = {1'b0, b_q[WIDTH-1:1]};
        cy = b_q[0];
      end
      3'b100: begin
        sum = {1'b0, b_q} + {1'b0, {WIDTH{1'b1}}};
        res = sum[WIDTH-1:0];
        cy = sum[WIDTH];
      end
      default: res = a_q;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start)
        state_n = (MUL_EN && inst[4] && inst[3:1] == 3'b101) ? MUL :
                  (inst[4] && inst[3:1] == 3'b110) ? LDW : EXEC;
      EXEC: state_n = WB;
      MUL:  state_n = last ? WB : MUL;
      LDW:  state_n = data_valid ? WB : LDW;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      inst_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
      d_out <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          inst_q <= inst;
          a_q <= rd_data;
          b_q <= rs_data;
          acc <= '0;
          cnt <= '0;
        end
        EXEC: if (arm) begin
          d_out <= res;
          flag_z <= res == '0;
          flag_c <= cy;
        end
        // multiplicand walks left while the multiplier bit under test walks right
        MUL: begin
          acc <= acc_n;
          a_q <= a_q << 1;
          b_q <= b_q >> 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            d_out <= acc_n;
            flag_z <= acc_n == '0;
            flag_c <= 1'b0;
          end
        end
        LDW: if (data_valid) begin
          d_out <= data_b;
          flag_z <= data_b == '0;
          flag_c <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_arm_alu_mc.sv
// tb_arm_alu_mc: directed and random instructions checked against an arithmetic reference model
module tb_arm_alu_mc;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, data_valid = 1'b0;
  logic [4:0] inst = '0;
  logic [W-1:0] rd_data = '0, rs_data = '0, data_b = '0;
  logic [W-1:0] d_out;
  logic wen, done, busy, flag_z, flag_c;
  int checks = 0, errors = 0;
  longint exp_d = 0;
  logic exp_z = 1'b0, exp_c = 1'b0;

  arm_alu_mc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .inst(inst), .rd_data(rd_data),
    .rs_data(rs_data), .data_b(data_b), .data_valid(data_valid), .d_out(d_out),
    .wen(wen), .done(done), .busy(busy), .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_inst(input logic [4:0] i, input logic [W-1:0] rd, input logic [W-1:0] rs,
                          input logic [W-1:0] db, input int waits, input string tag);
    longint m, a, b, r, s;
    logic c;
    int n, lat;
    m = longint'(1) << W;
    a = longint'(rd);
    b = longint'(rs);
    c = 1'b0;
    lat = 2;
    case (i[3:1])
      3'd0: begin s = a + b; r = s % m; c = s >= m; end
      3'd1: begin s = a + (m - 1 - b) + 1; r = s % m; c = s >= m; end
      3'd2: r = (b + longint'(i[0])) % m;
      3'd3: begin r = b / 2; c = b[0]; end
      3'd4: begin s = b + m - 1; r = s % m; c = s >= m; end
      3'd5: begin r = (a * b) % m; if (i[4]) lat = W + 1; end
      3'd6: begin r = longint'(db); if (i[4]) lat = 2 + waits; end
      default: r = a;
    endcase
    if (i[4]) begin
      exp_d = r;
      exp_z = r == 0;
      exp_c = c;
    end
    @(negedge clk);
    start = 1'b1;
    inst = i;
    rd_data = rd;
    rs_data = rs;
    data_valid = 1'b0;
    @(posedge clk);
    #1;
    n = 1;
    check({tag, "_busy"}, busy, 1);
    // keep start high with garbage operands for the whole run: all of it must be ignored
    while (!done && n < 200) begin
      inst = 5'($urandom);
      rd_data = W'($urandom);
      rs_data = W'($urandom);
      data_valid = n + 1 >= 2 + waits;
      data_b = data_valid ? db : W'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_wen"}, wen, i[4]);
    check({tag, "_d_out"}, d_out, exp_d);
    check({tag, "_flag_z"}, flag_z, exp_z);
    check({tag, "_flag_c"}, flag_c, exp_c);
    data_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_wen_pulse"}, wen, 0);
    check({tag, "_wb_start_ignored"}, busy, 0);
    start = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset_d_out", d_out, 0);
    check("reset_flags", {flag_z, flag_c}, 0);
    check("reset_ctrl", {wen, done, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_inst(5'b10000, 16'hFFFF, 16'h0001, 16'h0, 0, "add");
    check("add_vec", {d_out, flag_z, flag_c}, {16'h0000, 2'b11});
    run_inst(5'b10010, 16'h0005, 16'h0007, 16'h0, 0, "sub");
    check("sub_vec", {d_out, flag_z, flag_c}, {16'hFFFE, 2'b00});
    run_inst(5'b10110, 16'h0000, 16'h0003, 16'h0, 0, "lsr");
    check("lsr_vec", {d_out, flag_c}, {16'h0001, 1'b1});
    run_inst(5'b11010, 16'h0123, 16'h0010, 16'h0, 0, "mul");
    check("mul_vec", d_out, 16'h1230);
    run_inst(5'b11100, 16'h1111, 16'h2222, 16'hBEEF, 3, "ldr");
    check("ldr_vec", d_out, 16'hBEEF);
    run_inst(5'b00000, 16'h1234, 16'h5678, 16'h0, 0, "nonarm");
    check("nonarm_keep", d_out, 16'hBEEF);
    run_inst(5'b10101, 16'h0000, 16'hFFFF, 16'h0, 0, "mov_wrap");
    run_inst(5'b11000, 16'h0000, 16'h0000, 16'h0, 0, "dec_zero");
    run_inst(5'b11110, 16'hABCD, 16'h0000, 16'h0, 0, "op7");
    @(negedge clk);
    start = 1'b1;
    inst = 5'b11010;
    rd_data = 16'h0123;
    rs_data = 16'h0010;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int e = 2; e <= 8; e++) begin
      @(posedge clk);
      #1;
      check("abort_no_wen", wen, 0);
    end
    rst = 1'b1;
    #1;
    check("abort_d_out", d_out, 0);
    check("abort_flags", {flag_z, flag_c}, 0);
    check("abort_ctrl", {wen, done, busy}, 0);
    exp_d = 0;
    exp_z = 1'b0;
    exp_c = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_inst(5'b00000, 16'h0001, 16'h0002, 16'h0, 0, "post_reset");
    for (int k = 0; k < 80; k++)
      run_inst(5'($urandom), W'($urandom), W'($urandom_range(0, 3) == 0 ? 0 : $urandom),
               W'($urandom), $urandom_range(0, 4), "rand");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
